// File: rtl/present_affine_pipe.sv
// present_affine_pipe
//   Registered, share-wise PRESENT affine layer (input / middle / output affine
//   or bypass, chosen per beat). It sits between nonlinear stages of a masked
//   S-box pipeline. The round constant goes into share 0 only, so the XOR of all
//   output shares equals the unshared affine of the XOR of all input shares.
//   A 2-entry elastic buffer (main M + skid S) provides valid/ready flow control.
//   out_data comes straight from flops, so no glitches reach the next nonlinear
//   stage.
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   input beat valid
//   in_ready   beat can be accepted (registered state only)
//   in_mode    0=input affine, 1=middle, 2=output affine, 3=bypass
//   in_data    share s at [s*W +: W], nibble n of a share at [n*4 +: 4]
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_data   transformed shares, same layout as in_data
//   out_mode   mode that produced out_data
module present_affine_pipe #(
  parameter int SHARES  = 3,
  parameter int NIBBLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_mode,
  input  logic [SHARES*4*NIBBLES-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SHARES*4*NIBBLES-1:0]  out_data,
  output logic [1:0]                   out_mode
);

  localparam int W  = 4 * NIBBLES;
  localparam int DW = SHARES * W;

  // c is 1 only for share 0; every other share gets the purely linear part.
  function automatic logic [3:0] affine_nib(input logic [3:0] x, input logic c,
                                            input logic [1:0] mode);
    logic [3:0] y;
    case (mode)
      2'd0:    y = {x[1] ^ x[2] ^ c, x[1], x[3], x[0]};
      2'd1:    y = {x[0] ^ x[1], x[0], x[2], x[2] ^ x[3]};
      2'd2:    y = {c ^ x[1] ^ x[2] ^ x[3], x[0] ^ x[2] ^ x[3],
                    x[1] ^ x[2], x[0] ^ x[3] ^ c};
      default: y = x;
    endcase
    return y;
  endfunction

  logic [DW-1:0] aff_data;
  logic [DW-1:0] m_data, s_data;
  logic [1:0]    m_mode, s_mode;
  logic          m_full, s_full;
  logic          acc, pop;

  always_comb begin
    aff_data = '0;
    for (int s = 0; s < SHARES; s++) begin
      for (int n = 0; n < NIBBLES; n++) begin
        aff_data[s*W + n*4 +: 4] = affine_nib(in_data[s*W + n*4 +: 4], (s == 0), in_mode);
      end
    end
  end

  // in_ready depends only on registered state and rst, never on out_ready.
  assign in_ready  = ~s_full & ~rst;
  assign out_valid = m_full;
  assign out_data  = m_data;
  assign out_mode  = m_mode;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_full <= 1'b0;
      s_full <= 1'b0;
      m_data <= '0;
      m_mode <= 2'd0;
      s_data <= '0;
      s_mode <= 2'd0;
    end else if (pop & s_full) begin
      // S refills M; acc cannot coincide because in_ready is low while S is full.
      m_data <= s_data;
      m_mode <= s_mode;
      s_full <= 1'b0;
    end else if (acc & (~m_full | pop)) begin
      m_data <= aff_data;
      m_mode <= in_mode;
      m_full <= 1'b1;
    end else if (acc) begin
      // M full and not draining: overflow into the skid register.
      s_data <= aff_data;
      s_mode <= in_mode;
      s_full <= 1'b1;
    end else if (pop) begin
      m_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_present_affine_pipe.sv
module tb_present_affine_pipe;

  localparam int SHARES  = 3;
  localparam int NIBBLES = 16;
  localparam int W       = 4 * NIBBLES;
  localparam int DW      = SHARES * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_mode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    mode;
    logic [W-1:0]  xin;
  } beat_t;

  beat_t sb[$];

  always #5 clk = ~clk;

  present_affine_pipe #(.SHARES(SHARES), .NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference nibble map written bit by bit from the affine equations.
  function automatic logic [3:0] ref_nib(input logic [3:0] x, input logic c, input logic [1:0] m);
    logic [3:0] y;
    y = x;
    if (m == 2'd0) begin
      y[3] = x[1] ^ x[2] ^ c;  y[2] = x[1];
      y[1] = x[3];             y[0] = x[0];
    end else if (m == 2'd1) begin
      y[3] = x[0] ^ x[1];      y[2] = x[0];
      y[1] = x[2];             y[0] = x[2] ^ x[3];
    end else if (m == 2'd2) begin
      y[3] = c ^ x[1] ^ x[2] ^ x[3];  y[2] = x[0] ^ x[2] ^ x[3];
      y[1] = x[1] ^ x[2];             y[0] = x[0] ^ x[3] ^ c;
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] ref_shares(input logic [DW-1:0] d, input logic [1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int s = 0; s < SHARES; s++)
      for (int n = 0; n < NIBBLES; n++)
        r[s*W + n*4 +: 4] = ref_nib(d[s*W + n*4 +: 4], (s == 0), m);
    return r;
  endfunction

  function automatic logic [W-1:0] xor_shares(input logic [DW-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int s = 0; s < SHARES; s++) r ^= d[s*W +: W];
    return r;
  endfunction

  function automatic logic [W-1:0] ref_unshared(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    for (int n = 0; n < NIBBLES; n++) r[n*4 +: 4] = ref_nib(x[n*4 +: 4], 1'b1, m);
    return r;
  endfunction

  function automatic logic [DW-1:0] mk(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
    logic [DW-1:0] d;
    d = '0;
    d[3:0] = s0;
    d[W +: 4] = s1;
    d[2*W +: 4] = s2;
    return d;
  endfunction

  // One clock cycle: drive, then at the falling edge retire/accept beats.
  task automatic step(input logic v, input logic [1:0] m, input logic [DW-1:0] d, input logic r);
    beat_t b;
    in_valid = v; in_mode = m; in_data = d; out_ready = r;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("pop_has_expected_beat", DW'(sb.size() != 0), DW'(1));
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("out_data", out_data, b.data);
        check("out_mode", DW'(out_mode), DW'(b.mode));
        check("share_xor", DW'(xor_shares(out_data)), DW'(ref_unshared(b.xin, b.mode)));
      end
    end
    if (in_valid && in_ready) begin
      b.data = ref_shares(in_data, in_mode);
      b.mode = in_mode;
      b.xin  = xor_shares(in_data);
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] held;
  logic [DW-1:0] rd;
  int            guard;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_mode", DW'(out_mode), DW'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", DW'(in_ready), DW'(1));

    // mode0 on share0 = 5: low nibble of share 0 must become 1 one cycle later
    step(1'b1, 2'd0, mk(4'h5, 4'h0, 4'h0), 1'b1);
    check("t1_latency_valid", DW'(out_valid), DW'(1));
    check("t1_s0_nib0", DW'(out_data[3:0]), DW'(4'h1));
    check("t1_s1_nib0", DW'(out_data[W +: 4]), DW'(4'h0));
    // mode2 back-to-back: zero input gives 9 in share 0; share1 = 3 gives F
    step(1'b1, 2'd2, mk(4'h0, 4'h3, 4'h0), 1'b1);
    check("t2_no_bubble", DW'(out_valid), DW'(1));
    check("t2_s0_nib0", DW'(out_data[3:0]), DW'(4'h9));
    check("t2_s1_nib0", DW'(out_data[W +: 4]), DW'(4'hF));
    step(1'b1, 2'd1, {DW{1'b1}}, 1'b1);
    check("t3_mode1_s2", DW'(out_data[2*W +: 4]), DW'(4'h6));
    step(1'b1, 2'd3, mk(4'hC, 4'h5, 4'hA), 1'b1);
    check("t3_bypass", DW'(out_data[2*W +: 4] == 4'hA && out_data[W +: 4] == 4'h5 &&
                           out_data[3:0] == 4'hC), DW'(1));
    step(1'b0, 2'd0, '0, 1'b1);

    // backpressure: two beats fill M and S
    step(1'b1, 2'd0, mk(4'h1, 4'h2, 4'h3), 1'b0);
    step(1'b1, 2'd2, mk(4'h4, 4'h5, 4'h6), 1'b0);
    check("bp_in_ready_low", DW'(in_ready), DW'(0));
    check("bp_out_valid", DW'(out_valid), DW'(1));
    held = out_data;
    check("bp_front", out_data, sb[0].data);
    step(1'b1, 2'd1, mk(4'h7, 4'h8, 4'h9), 1'b0);
    check("bp_stable", out_data, held);
    check("bp_depth", DW'(sb.size()), DW'(2));
    repeat (3) step(1'b0, 2'd0, '0, 1'b1);
    check("bp_drained", DW'(sb.size()), DW'(0));
    check("bp_in_ready_back", DW'(in_ready), DW'(1));

    // random masks, modes, valid and ready
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < DW; k++) rd[k] = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rd,
           1'($urandom_range(0, 2) != 0));
    end
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step(1'b0, 2'd0, '0, 1'b1);
      guard++;
    end
    check("rand_drain", DW'(sb.size()), DW'(0));

    // reset with M and S both full
    step(1'b1, 2'd0, mk(4'hA, 4'hB, 4'hC), 1'b0);
    step(1'b1, 2'd2, mk(4'hD, 4'hE, 4'hF), 1'b0);
    check("pre_rst_full", DW'(in_ready), DW'(0));
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", DW'(out_valid), DW'(0));
    check("mid_rst_out_data", out_data, '0);
    check("mid_rst_in_ready", DW'(in_ready), DW'(0));
    sb.delete();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, '0, 1'b1);
      check("no_stale_beat", DW'(out_valid), DW'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
